// File: rtl/reg_file_pkg.sv
// Shared defaults and request decoding for the small register-file blocks.
package reg_file_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 3;
    localparam int unsigned RF_DATA_WIDTH = 16;
    localparam int unsigned RF_DEPTH      = 2 ** RF_ADDR_WIDTH;

    typedef enum logic [1:0] {
        OP_IDLE     = 2'b00,
        OP_READ     = 2'b01,
        OP_WRITE    = 2'b10,
        OP_CONFLICT = 2'b11
    } rf_op_e;

    // Simultaneous read and write requests collapse to a no-op (OP_CONFLICT).
    function automatic rf_op_e decode_op(input logic wr_en, input logic rd_en);
        rf_op_e op;
        case ({wr_en, rd_en})
            2'b01:   op = OP_READ;
            2'b10:   op = OP_WRITE;
            2'b11:   op = OP_CONFLICT;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register8_16.sv
// Register-array memory (DEPTH x DATA_WIDTH): single-cycle writes and
// registered reads with a one-cycle valid strobe.
module register8_16
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned DEPTH      = RF_DEPTH
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [DATA_WIDTH-1:0] WrData,
    input  logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  RdData_Valid
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    rf_op_e w_op;
    logic   w_addr_ok;

    always_comb begin
        w_op      = decode_op(WrEn, RdEn);
        // Guards against addresses beyond a DEPTH smaller than 2**ADDR_WIDTH.
        w_addr_ok = (32'(Address) < DEPTH);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            unique case (w_op)
                OP_WRITE: begin
                    if (w_addr_ok) begin
                        r_mem[Address] <= WrData;
                    end
                end
                OP_READ: begin
                    r_rd_data  <= w_addr_ok ? r_mem[Address] : '0;
                    r_rd_valid <= 1'b1;
                end
                OP_IDLE, OP_CONFLICT: begin
                end
            endcase
        end
    end

    assign RdData       = r_rd_data;
    assign RdData_Valid = r_rd_valid;

endmodule

// File: tb/tb_register8_16.sv
// Directed and scoreboard-checked stimulus for register8_16.
module tb_register8_16;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        WrEn = 1'b0;
    logic        RdEn = 1'b0;
    logic [15:0] WrData = '0;
    logic [2:0]  Address = '0;
    logic [15:0] RdData;
    logic        RdData_Valid;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [15:0] model [8];

    register8_16 #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .DEPTH(8)) dut (
        .clk          (clk),
        .RST          (RST),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .WrData       (WrData),
        .Address      (Address),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request at the falling edge; return 1 time unit after the next rising edge.
    task automatic cycle(input logic wr, input logic rd, input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        WrEn    = wr;
        RdEn    = rd;
        Address = a;
        WrData  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        cycle(1'b0, 1'b1, a, 16'h0);
        check_eq({tag, "_data"}, 32'(RdData), 32'(exp));
        check_eq({tag, "_valid"}, 32'(RdData_Valid), 32'd1);
    endtask

    initial begin
        logic [2:0]  ra;
        logic [15:0] rd;

        #1 RST = 1'b1;
        #2;
        check_eq("rst_data", 32'(RdData), 32'h0);
        check_eq("rst_valid", 32'(RdData_Valid), 32'h0);
        @(negedge clk);
        RST = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0;

        for (int i = 0; i < 8; i++) read_check($sformatf("rst_rd%0d", i), 3'(i), 16'h0000);

        cycle(1'b0, 1'b0, 3'd0, 16'h0);
        check_eq("idle_valid", 32'(RdData_Valid), 32'h0);

        cycle(1'b1, 1'b0, 3'd4, 16'h0007);
        check_eq("wr4_valid", 32'(RdData_Valid), 32'h0);
        read_check("rd4", 3'd4, 16'h0007);

        cycle(1'b1, 1'b0, 3'd3, 16'hA5A5);
        cycle(1'b1, 1'b0, 3'd3, 16'h1234);
        read_check("rd3_last", 3'd3, 16'h1234);

        cycle(1'b0, 1'b0, 3'd5, 16'h0);
        check_eq("idle_hold", 32'(RdData), 32'h1234);

        read_check("rd4_again", 3'd4, 16'h0007);
        cycle(1'b1, 1'b1, 3'd2, 16'hFFFF);
        check_eq("dual_hold", 32'(RdData), 32'h0007);
        check_eq("dual_valid", 32'(RdData_Valid), 32'h0);
        read_check("rd2_nowrite", 3'd2, 16'h0000);

        cycle(1'b1, 1'b0, 3'd7, 16'hBEEF);
        read_check("rd7", 3'd7, 16'hBEEF);
        // Reset in the high phase while a write is being presented.
        WrEn = 1'b1; Address = 3'd1; WrData = 16'h5555;
        #2 RST = 1'b1;
        #1;
        check_eq("midrst_data", 32'(RdData), 32'h0);
        check_eq("midrst_valid", 32'(RdData_Valid), 32'h0);
        @(negedge clk);
        RST = 1'b0;
        WrEn = 1'b0;
        read_check("rd7_cleared", 3'd7, 16'h0000);
        read_check("rd3_cleared", 3'd3, 16'h0000);
        read_check("rd1_discard", 3'd1, 16'h0000);

        for (int i = 0; i < 8; i++) model[i] = 16'h0;
        for (int it = 0; it < 100; it++) begin
            ra = 3'($urandom_range(0, 7));
            rd = 16'($urandom);
            if (it % 10 == 9) begin
                cycle(1'b1, 1'b1, ra, rd);
            end else begin
                cycle(1'b1, 1'b0, ra, rd);
                model[ra] = rd;
            end
            read_check($sformatf("rnd%0d", it), ra, model[ra]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register8_16.md
REGISTER8_16 -- requirements
Module: register8_16

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: address width in bits.
REQ-002 Parameter DATA_WIDTH, default 16: word width in bits.
REQ-003 Parameter DEPTH, default 8 (2**ADDR_WIDTH): number of words.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 WrEn  input  1  write request.
REQ-008 RdEn  input  1  read request.
REQ-009 WrData  input  DATA_WIDTH  write data.
REQ-010 Address  input  ADDR_WIDTH  word address for read or write.
REQ-011 RdData  output  DATA_WIDTH  registered read data.
REQ-012 RdData_Valid  output  1  high for one cycle when RdData was updated by a read.

Function
REQ-013 Storage SHALL be DEPTH words of DATA_WIDTH bits, all addresses 0..DEPTH-1 valid.
REQ-014 WrEn=1, RdEn=0 at a rising edge SHALL write WrData to mem[Address]; visible to a read on the next cycle.
REQ-015 RdEn=1, WrEn=0 at a rising edge SHALL load RdData with mem[Address] and set RdData_Valid=1 (one-cycle latency).
REQ-016 WrEn=1 and RdEn=1 together SHALL perform no operation: memory unchanged, RdData held, RdData_Valid=0.
REQ-017 WrEn=0 and RdEn=0 SHALL leave memory unchanged, hold RdData, and drive RdData_Valid=0.
REQ-018 RdData SHALL hold its last read value until the next accepted read or reset.
REQ-019 Repeated writes to one address SHALL overwrite; the last write wins.
REQ-020 Writes SHALL store the full DATA_WIDTH word with no masking.

Reset
REQ-021 While RST=1, every memory word SHALL be 0, RdData=0 and RdData_Valid=0, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard any in-flight read or write.
REQ-023 On the first rising edge after RST falls, the block SHALL accept requests normally.

Structure
REQ-024 ADDR_WIDTH, DATA_WIDTH and DEPTH defaults SHALL live in a shared package (reg_file_pkg).
REQ-025 The design SHALL be a single flat module with no sub-modules; memory is a register array, not a macro.

Verification
REQ-026 Assert RST one cycle, then read addresses 0..7 -> RdData=0x0000 each, RdData_Valid=1 one cycle after each RdEn.
REQ-027 Write 0x0007 to address 4, then read address 4 -> RdData=0x0007 after one cycle.
REQ-028 Write 0xA5A5 then 0x1234 to address 3, then read address 3 -> RdData=0x1234.
REQ-029 Write 0xFFFF to address 2 with WrEn=RdEn=1, then read address 2 -> RdData=0x0000, and RdData held during the dual-enable cycle.
REQ-030 Write 0xBEEF to address 7, read it, then assert RST mid-cycle -> RdData=0 immediately; a later read of address 7 -> 0x0000.
REQ-031 Random address/data write-then-read over 100 iterations, checked against a scoreboard model -> no mismatches.
